// File: rtl/fila_cmd.sv
// fila_cmd: push-button command front end for an 8-entry queue.
// Conditions the enqueue/dequeue buttons, turns debounced presses into
// one-cycle queue requests and tracks rejected commands.
module fila_cmd #(
    parameter int unsigned DEBOUNCE_CYCLES = 100
) (
    input  logic       clock_10KHz,
    input  logic       reset,
    input  logic       btn_enq_in,
    input  logic       btn_deq_in,
    input  logic [7:0] switches_in,
    input  logic [7:0] len_in,
    input  logic [7:0] fila_data_in,
    output logic       enqueue_out,
    output logic       dequeue_out,
    output logic [7:0] data_out,
    output logic [7:0] last_deq_out,
    output logic       busy_out,
    output logic       err_full_out,
    output logic       err_empty_out,
    output logic [3:0] reject_cnt_out
);

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned REJ_W       = 4;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned NUM_BTN     = 2;
    localparam int unsigned BTN_ENQ     = 0;
    localparam int unsigned BTN_DEQ     = 1;
    localparam int unsigned QUEUE_DEPTH = 8;

    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REJ_W-1:0]  REJ_MAX   = '1;
    localparam logic [DATA_W-1:0] LEN_LIMIT = DATA_W'(QUEUE_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ENQ,
        ENQ_HOLD,
        DEQ,
        DEQ_WAIT,
        DEQ_CAP
    } state_t;

    // Button conditioning state, bit 0 = enqueue, bit 1 = dequeue
    logic [NUM_BTN-1:0]            sync1_q, sync1_d;
    logic [NUM_BTN-1:0]            sync2_q, sync2_d;
    logic [NUM_BTN-1:0]            db_q, db_d;
    logic [NUM_BTN-1:0]            db_prev_q, db_prev_d;
    logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_BTN-1:0]            btn_evt_c;

    // Command FSM and output registers
    state_t              state_q, state_d;
    logic                hold_q, hold_d;
    logic                enq_q, enq_d;
    logic                deq_q, deq_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   last_q, last_d;
    logic                err_full_q, err_full_d;
    logic                err_empty_q, err_empty_d;
    logic [REJ_W-1:0]    rej_q, rej_d;
    logic [REJ_W-1:0]    rej_inc_c;

    // Synchronize raw buttons and accept a new level only after it has held steady
    always_comb begin
        sync1_d   = {btn_deq_in, btn_enq_in};
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        cnt_d     = '0;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Button conditioning registers
    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            cnt_q     <= cnt_d;
        end
    end

    // One-cycle command event on each debounced press (release is ignored)
    assign btn_evt_c = db_q & ~db_prev_q;

    assign rej_inc_c = (rej_q == REJ_MAX) ? rej_q : rej_q + REJ_W'(1);

    // Next state and registered outputs; request pulses are taken from the
    // current state so they trail the state by one cycle, which fixes the
    // dequeue capture at three edges after the edge that raised dequeue_out
    always_comb begin
        state_d     = state_q;
        hold_d      = 1'b0;
        data_d      = data_q;
        last_d      = last_q;
        err_full_d  = err_full_q;
        err_empty_d = err_empty_q;
        rej_d       = rej_q;

        case (state_q)
            IDLE: begin
                if (btn_evt_c[BTN_ENQ]) begin
                    if (len_in < LEN_LIMIT) begin
                        data_d      = switches_in;
                        err_full_d  = 1'b0;
                        err_empty_d = 1'b0;
                        state_d     = ENQ;
                    end else begin
                        err_full_d = 1'b1;
                        rej_d      = rej_inc_c;
                    end
                end else if (btn_evt_c[BTN_DEQ]) begin
                    if (len_in != '0) begin
                        err_full_d  = 1'b0;
                        err_empty_d = 1'b0;
                        state_d     = DEQ;
                    end else begin
                        err_empty_d = 1'b1;
                        rej_d       = rej_inc_c;
                    end
                end
            end
            ENQ: begin
                state_d = ENQ_HOLD;
            end
            ENQ_HOLD: begin
                if (hold_q) begin
                    state_d = IDLE;
                end else begin
                    hold_d = 1'b1;
                end
            end
            DEQ: begin
                state_d = DEQ_WAIT;
            end
            DEQ_WAIT: begin
                if (hold_q) begin
                    state_d = DEQ_CAP;
                end else begin
                    hold_d = 1'b1;
                end
            end
            DEQ_CAP: begin
                last_d  = fila_data_in;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        enq_d  = (state_q == ENQ);
        deq_d  = (state_q == DEQ);
        busy_d = (state_d != IDLE);
    end

    // FSM state and output registers
    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= 1'b0;
            enq_q       <= 1'b0;
            deq_q       <= 1'b0;
            busy_q      <= 1'b0;
            data_q      <= '0;
            last_q      <= '0;
            err_full_q  <= 1'b0;
            err_empty_q <= 1'b0;
            rej_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            enq_q       <= enq_d;
            deq_q       <= deq_d;
            busy_q      <= busy_d;
            data_q      <= data_d;
            last_q      <= last_d;
            err_full_q  <= err_full_d;
            err_empty_q <= err_empty_d;
            rej_q       <= rej_d;
        end
    end

    assign enqueue_out    = enq_q;
    assign dequeue_out    = deq_q;
    assign data_out       = data_q;
    assign last_deq_out   = last_q;
    assign busy_out       = busy_q;
    assign err_full_out   = err_full_q;
    assign err_empty_out  = err_empty_q;
    assign reject_cnt_out = rej_q;

endmodule

// File: tb/tb_fila_cmd.sv
// tb_fila_cmd: directed bench for fila_cmd with a cycle-level reference model.
module tb_fila_cmd;

    localparam int N = 4;

    logic       clk;
    logic       reset;
    logic       btn_enq;
    logic       btn_deq;
    logic [7:0] switches;
    logic [7:0] len;
    logic [7:0] fila_data;
    logic       enqueue_out;
    logic       dequeue_out;
    logic [7:0] data_out;
    logic [7:0] last_deq_out;
    logic       busy_out;
    logic       err_full_out;
    logic       err_empty_out;
    logic [3:0] reject_cnt_out;

    int checks   = 0;
    int failures = 0;
    int enq_total  = 0;
    int deq_total  = 0;
    int busy_total = 0;

    fila_cmd #(.DEBOUNCE_CYCLES(N)) dut (
        .clock_10KHz   (clk),
        .reset         (reset),
        .btn_enq_in    (btn_enq),
        .btn_deq_in    (btn_deq),
        .switches_in   (switches),
        .len_in        (len),
        .fila_data_in  (fila_data),
        .enqueue_out   (enqueue_out),
        .dequeue_out   (dequeue_out),
        .data_out      (data_out),
        .last_deq_out  (last_deq_out),
        .busy_out      (busy_out),
        .err_full_out  (err_full_out),
        .err_empty_out (err_empty_out),
        .reject_cnt_out(reject_cnt_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: button level flips once the N samples that reached the
    // synchronizer output all disagree with it; a command occupies a fixed
    // timeline measured in edges since acceptance.
    bit         m_hist [2][N+2];
    bit   [1:0] m_lvl;
    bit   [1:0] m_pend;
    int         m_age;
    bit         m_mode;
    bit         m_enq, m_deq, m_busy, m_ef, m_ee;
    logic [7:0] m_data, m_last;
    int         m_rej;

    initial begin : model
        bit       idle;
        bit       all_diff;
        bit [1:0] raw;
        bit [1:0] ev;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int b = 0; b < 2; b++)
                    for (int j = 0; j < N + 2; j++) m_hist[b][j] = 1'b0;
                m_lvl = '0; m_pend = '0; m_age = 99; m_mode = 1'b0;
                m_enq = 0; m_deq = 0; m_busy = 0; m_ef = 0; m_ee = 0;
                m_data = 8'h00; m_last = 8'h00; m_rej = 0;
            end else begin
                idle = (m_age >= (m_mode ? 4 : 3));
                ev   = m_pend;
                if (m_mode && m_age == 3) m_last = fila_data;
                raw = {btn_deq, btn_enq};
                for (int b = 0; b < 2; b++) begin
                    for (int j = N + 1; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
                    m_hist[b][0] = raw[b];
                    all_diff = 1'b1;
                    for (int j = 2; j <= N + 1; j++)
                        if (m_hist[b][j] == m_lvl[b]) all_diff = 1'b0;
                    m_pend[b] = 1'b0;
                    if (all_diff) begin
                        m_lvl[b]  = ~m_lvl[b];
                        m_pend[b] = m_lvl[b];
                    end
                end
                if (m_age < 99) m_age++;
                if (idle && ev[0]) begin
                    if (len < 8) begin
                        m_data = switches; m_ef = 0; m_ee = 0; m_mode = 0; m_age = 0;
                    end else begin
                        m_ef = 1; if (m_rej < 15) m_rej++;
                    end
                end else if (idle && ev[1]) begin
                    if (len > 0) begin
                        m_ef = 0; m_ee = 0; m_mode = 1; m_age = 0;
                    end else begin
                        m_ee = 1; if (m_rej < 15) m_rej++;
                    end
                end
                m_enq  = !m_mode && m_age == 1;
                m_deq  = m_mode && m_age == 1;
                m_busy = m_age < (m_mode ? 4 : 3);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin : compare
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("enqueue_out", enqueue_out, m_enq);
                check("dequeue_out", dequeue_out, m_deq);
                check("busy_out", busy_out, m_busy);
                check("data_out", data_out, m_data);
                check("last_deq_out", last_deq_out, m_last);
                check("err_full_out", err_full_out, m_ef);
                check("err_empty_out", err_empty_out, m_ee);
                check("reject_cnt_out", reject_cnt_out, 8'(m_rej));
                check("enq_deq_exclusive", enqueue_out & dequeue_out, 8'h00);
                if (enqueue_out) enq_total++;
                if (dequeue_out) deq_total++;
                if (busy_out)    busy_total++;
            end
        end
    end

    // Downstream queue stand-in: presents the next stored value two edges after
    // it sees a dequeue request
    logic [7:0] q_vals [4] = '{8'h3C, 8'h77, 8'h91, 8'h4D};
    int         q_idx = 0;
    initial begin : queue_model
        fila_data = 8'hEE;
        forever begin
            @(posedge clk);
            #1;
            if (dequeue_out) begin
                @(posedge clk);
                @(posedge clk);
                #1;
                if (!reset) begin
                    fila_data = q_vals[q_idx % 4];
                    q_idx++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input bit use_deq, input int hold, input int gap);
        if (use_deq) btn_deq = 1'b1; else btn_enq = 1'b1;
        step(hold);
        btn_enq = 1'b0;
        btn_deq = 1'b0;
        step(gap);
    endtask

    initial begin : stimulus
        int e0, d0, b0;
        reset = 1'b1; btn_enq = 1'b0; btn_deq = 1'b0;
        switches = 8'h00; len = 8'h00;
        step(3);
        check("reset_busy", busy_out, 8'h00);
        check("reset_data", data_out, 8'h00);
        check("reset_rej", reject_cnt_out, 8'h00);
        check("reset_enq", enqueue_out, 8'h00);
        reset = 1'b0;
        step(3);

        // Clean enqueue press: acceptance 6 edges after first sample
        switches = 8'hA5; len = 8'd0;
        e0 = enq_total; b0 = busy_total;
        btn_enq = 1'b1;
        step(7);
        check("t1_busy_accept", busy_out, 8'h01);
        check("t1_data_accept", data_out, 8'hA5);
        check("t1_enq_not_yet", enqueue_out, 8'h00);
        step(1);
        check("t1_enq_pulse", enqueue_out, 8'h01);
        step(1);
        check("t1_enq_done", enqueue_out, 8'h00);
        check("t1_busy_hold", busy_out, 8'h01);
        step(1);
        check("t1_busy_end", busy_out, 8'h00);
        check("t1_data_held", data_out, 8'hA5);
        btn_enq = 1'b0;
        step(10);
        check("t1_enq_count", 8'(enq_total - e0), 8'd1);
        check("t1_busy_cycles", 8'(busy_total - b0), 8'd3);

        // Dequeue from an empty queue is rejected
        d0 = deq_total;
        press(1'b1, 10, 10);
        check("empty_err", err_empty_out, 8'h01);
        check("empty_rej", reject_cnt_out, 8'd1);
        check("empty_no_deq", 8'(deq_total - d0), 8'd0);

        // Normal dequeue captures the presented value and clears flags
        len = 8'd3;
        d0 = deq_total;
        press(1'b1, 10, 10);
        check("t2_last", last_deq_out, 8'h3C);
        check("t2_err_empty", err_empty_out, 8'h00);
        check("t2_err_full", err_full_out, 8'h00);
        check("t2_deq_count", 8'(deq_total - d0), 8'd1);
        check("t2_rej_kept", reject_cnt_out, 8'd1);

        // Bouncing button: one event, accepted 6 edges after it steadies
        len = 8'd2; switches = 8'h11;
        e0 = enq_total;
        for (int i = 0; i < 10; i++) begin
            btn_enq = (i % 2 == 0);
            step(2);
        end
        btn_enq = 1'b1;
        step(6);
        check("t4_not_early", busy_out, 8'h00);
        check("t4_no_bounce_evt", 8'(enq_total - e0), 8'd0);
        step(1);
        check("t4_accept", busy_out, 8'h01);
        step(5);
        btn_enq = 1'b0;
        step(10);
        check("t4_enq_count", 8'(enq_total - e0), 8'd1);
        check("t4_data", data_out, 8'h11);

        // Simultaneous presses act as enqueue only
        switches = 8'h5A; len = 8'd2;
        e0 = enq_total; d0 = deq_total;
        btn_enq = 1'b1; btn_deq = 1'b1;
        step(7);
        check("t5_data", data_out, 8'h5A);
        step(10);
        btn_enq = 1'b0; btn_deq = 1'b0;
        step(10);
        check("t5_enq_count", 8'(enq_total - e0), 8'd1);
        check("t5_no_deq", 8'(deq_total - d0), 8'd0);
        check("t5_rej_same", reject_cnt_out, 8'd1);

        // Dequeue press landing in ENQ_HOLD is dropped
        switches = 8'h66; len = 8'd0;
        d0 = deq_total;
        btn_enq = 1'b1;
        step(2);
        btn_deq = 1'b1;
        step(12);
        btn_enq = 1'b0; btn_deq = 1'b0;
        step(10);
        check("t5b_no_deq", 8'(deq_total - d0), 8'd0);
        check("t5b_err_empty", err_empty_out, 8'h00);
        check("t5b_rej_same", reject_cnt_out, 8'd1);
        check("t5b_data", data_out, 8'h66);

        // Reset during DEQ_WAIT aborts; held button re-fires after reset
        len = 8'd3;
        d0 = deq_total;
        btn_deq = 1'b1;
        for (int k = 0; k < 20 && !dequeue_out; k++) step(1);
        check("t6_deq_seen", dequeue_out, 8'h01);
        #4 reset = 1'b1;
        #1;
        check("t6_rst_deq", dequeue_out, 8'h00);
        check("t6_rst_busy", busy_out, 8'h00);
        check("t6_rst_last", last_deq_out, 8'h00);
        check("t6_rst_data", data_out, 8'h00);
        check("t6_rst_rej", reject_cnt_out, 8'h00);
        @(posedge clk);
        #2;
        step(1);
        reset = 1'b0;
        step(6);
        check("t6_not_early", busy_out, 8'h00);
        step(1);
        check("t6_refire", busy_out, 8'h01);
        btn_deq = 1'b0;
        step(12);
        check("t6_deq_count", 8'(deq_total - d0), 8'd2);
        check("t6_last", last_deq_out, 8'h77);

        // Full queue: 17 rejected enqueues saturate the counter at 15
        switches = 8'h99; len = 8'd8;
        e0 = enq_total;
        repeat (17) press(1'b0, 10, 10);
        check("t3_no_enq", 8'(enq_total - e0), 8'd0);
        check("t3_err_full", err_full_out, 8'h01);
        check("t3_rej_sat", reject_cnt_out, 8'd15);
        len = 8'd0;
        press(1'b1, 10, 10);
        check("t3_empty_sat", reject_cnt_out, 8'd15);
        check("t3_err_empty", err_empty_out, 8'h01);
        switches = 8'h42; len = 8'd7;
        e0 = enq_total;
        press(1'b0, 10, 10);
        check("t3_enq_ok", 8'(enq_total - e0), 8'd1);
        check("t3_full_clear", err_full_out, 8'h00);
        check("t3_empty_clear", err_empty_out, 8'h00);
        check("t3_data", data_out, 8'h42);
        check("t3_rej_kept", reject_cnt_out, 8'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fila_cmd.md
FILA_CMD -- requirements
Module: fila_cmd

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100 (10 ms at 10 kHz): consecutive stable cycles needed to accept a button level; legal range 2..65535.
REQ-002 SHALL have port clock_10KHz  input  1  system clock; all logic rises on its posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port btn_enq_in  input  1  raw, asynchronous enqueue push-button.
REQ-005 SHALL have port btn_deq_in  input  1  raw, asynchronous dequeue push-button.
REQ-006 SHALL have port switches_in  input  8  value to enqueue; sampled once, at command acceptance.
REQ-007 SHALL have port len_in  input  8  occupancy reported by the downstream queue.
REQ-008 SHALL have port fila_data_in  input  8  dequeued value presented by the downstream queue.
REQ-009 SHALL have port enqueue_out  output  1  one-cycle enqueue request to the queue.
REQ-010 SHALL have port dequeue_out  output  1  one-cycle dequeue request to the queue.
REQ-011 SHALL have port data_out  output  8  value driven to the queue's data input.
REQ-012 SHALL have port last_deq_out  output  8  most recently dequeued value.
REQ-013 SHALL have port busy_out  output  1  high whenever the FSM is not in IDLE.
REQ-014 SHALL have ports err_full_out and err_empty_out  output  1 each  sticky rejection flags.
REQ-015 SHALL have port reject_cnt_out  output  4  saturating count of rejected commands.

Function
REQ-016 Each button SHALL pass through a 2-flop synchronizer, then a debouncer: debounced level updates only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-017 A command event SHALL be a one-cycle pulse on the 0->1 transition of a debounced level; release (1->0) generates nothing.
REQ-018 The FSM SHALL have states IDLE, ENQ, ENQ_HOLD, DEQ, DEQ_WAIT, DEQ_CAP.
REQ-019 In IDLE, an enqueue event with len_in < 8 SHALL latch switches_in into data_out, clear both error flags, and go to ENQ.
REQ-020 In IDLE, an enqueue event with len_in >= 8 SHALL set err_full_out, increment reject_cnt_out, and stay in IDLE.
REQ-021 In IDLE, a dequeue event with len_in > 0 SHALL clear both error flags and go to DEQ; with len_in == 0 it SHALL set err_empty_out, increment reject_cnt_out, and stay in IDLE.
REQ-022 Simultaneous enqueue and dequeue events in IDLE SHALL act as enqueue only; the dequeue event is dropped and not counted.
REQ-023 ENQ SHALL assert enqueue_out for exactly one cycle, then go to ENQ_HOLD.
REQ-024 ENQ_HOLD SHALL last 2 cycles with data_out held constant, then return to IDLE; data_out SHALL stay stable until the next accepted enqueue.
REQ-025 DEQ SHALL assert dequeue_out for exactly one cycle, then go to DEQ_WAIT.
REQ-026 DEQ_WAIT SHALL last 2 cycles; DEQ_CAP SHALL load fila_data_in into last_deq_out on its closing edge, then return to IDLE.
REQ-027 Dequeue capture latency SHALL be fixed: fila_data_in is sampled at the edge 3 cycles after the edge that made dequeue_out high.
REQ-028 Command events arriving outside IDLE SHALL be silently dropped: no flags set, not counted.
REQ-029 reject_cnt_out SHALL saturate at 15 and never wrap.
REQ-030 enqueue_out and dequeue_out SHALL never be high in the same cycle; both SHALL be registered outputs.

Reset
REQ-031 reset SHALL immediately force IDLE, all outputs to 0, debounced levels to 0, and clear synchronizers and debounce counters.
REQ-032 Reset asserted mid-command SHALL abort it with no further pulse; a button still held at release SHALL produce one event once debounced, never earlier than DEBOUNCE_CYCLES+2 cycles after reset falls.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Reset, switches_in=0xA5, len_in=0, press enq clean -> exactly one enqueue_out pulse; data_out=0xA5 from acceptance through 2 cycles after the pulse; busy_out high 3 cycles.
REQ-034 len_in=3, press deq, queue model presents 0x3C 2 cycles after pulse -> last_deq_out=0x3C after DEQ_CAP; err flags 0.
REQ-035 len_in=8, press enq 17 times -> no enqueue_out, err_full_out=1, reject_cnt_out=15 (saturated); then len_in=7, enq -> accepted, err_full_out cleared.
REQ-036 Button bouncing 0/1 every 2 cycles for 20 cycles, then steady 1 -> exactly one event, accepted 4+2 cycles after it steadies.
REQ-037 Both buttons debounce in the same cycle, len_in=2 -> enqueue only, no dequeue_out, reject_cnt_out unchanged; press deq during ENQ_HOLD -> dropped.
REQ-038 Reset pulse during DEQ_WAIT -> all outputs 0 immediately, no capture, FSM in IDLE.
